mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have inputs ex_wd_i[4:0], ex_wreg_i, ex_wdata_i[31:0]: destination register, write enable and ALU result from the EX/MEM register.
REQ-004 SHALL have input mem_rw_i[1:0]: 00 none, 01 load, 10 store, 11 treated as none.
REQ-005 SHALL have inputs mem_addr_i[11:0] (byte address) and mem_data_i[31:0] (store data).
REQ-006 SHALL have input mem_sel_i[3:0]: [1:0] size (00 byte, 01 half, 10 word, 11 treated as word); [2] unsigned load; [3] ignored.
REQ-007 SHALL have input stall[5:0]: pipeline stall vector; only bits 4 and 5 are used.
REQ-008 SHALL have outputs dm_req_o, dm_we_o, dm_addr_o[11:0], dm_be_o[3:0], dm_wdata_o[31:0] to data memory, and inputs dm_ack_i and dm_rdata_i[31:0] from it.
REQ-009 SHALL have outputs mem_wd_o[4:0], mem_wreg_o, mem_wdata_o[31:0]: registered result to write-back.
REQ-010 SHALL have outputs stallreq_o (1 bit), fault_o (1 bit), fault_code_o[1:0] and fault_addr_o[11:0].

Function
REQ-011 SHALL implement FSM states IDLE and ACCESS.
REQ-012 A memory op SHALL be mem_rw_i in {01,10}, with both alignment rules met: half needs addr[0]=0, word needs addr[1:0]=0.
REQ-013 In IDLE with stall[5]=1, all registers SHALL hold and no access SHALL start.
REQ-014 In IDLE with stall[5]=0 and an aligned memory op, the next edge SHALL:
- enter ACCESS;
- latch the op fields;
- set dm_req_o=1;
- bubble the write-back outputs (wd=0, wreg=0, wdata=0).
REQ-015 In IDLE with stall[5]=0, no memory op and stall[4]=1, the next edge SHALL bubble the write-back outputs.
REQ-016 In IDLE with stall[5]=0, no memory op and stall[4]=0, the next edge SHALL register ex_wd_i, ex_wreg_i and ex_wdata_i into the outputs (1-cycle latency).
REQ-017 stallreq_o SHALL be combinational high when IDLE and an aligned memory op is present, and high throughout ACCESS.
REQ-018 Throughout ACCESS the memory outputs SHALL be driven as follows:
- dm_req_o=1;
- dm_addr_o = latched addr with [1:0] forced 0;
- dm_we_o=1 for a store, 0 for a load.
REQ-019 Byte enables dm_be_o SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, and 1111 for word.
REQ-020 dm_wdata_o SHALL carry the byte replicated x4 for byte, the half replicated x2 for half, and the full word for word.
REQ-021 An ACCESS cycle with dm_ack_i=1 SHALL complete the access at that edge:
- state returns to IDLE;
- dm_req_o drops;
- write-back outputs load the result.
REQ-022 The load result SHALL be the addressed byte or half of dm_rdata_i, extracted by addr[1:0]/addr[1], sign-extended unless sel[2]=1; a word load takes all 32 bits.
REQ-023 On completion, a load SHALL output wd=latched wd and wreg=1; a store SHALL output wreg=0 and wdata=0.
REQ-024 A 4-bit wait counter SHALL clear on ACCESS entry and increment on each ACCESS cycle without ack.
REQ-025 If the wait counter is 15 and dm_ack_i=0, the access SHALL abort:
- state returns to IDLE;
- wreg=0;
- fault_o pulses;
- fault_code_o=10 (timeout).
REQ-026 An ack in the same cycle as count 15 SHALL complete the access normally, with no fault.
REQ-027 In IDLE with stall[5]=0 and a misaligned load or store, there SHALL be no access and no stallreq; fault_o SHALL pulse with fault_code_o=01, and the outputs SHALL bubble.
REQ-028 fault_o SHALL be high for exactly one cycle per fault; fault_code_o and fault_addr_o SHALL hold their values until the next fault.
REQ-029 In ACCESS, stall[5:4] and all ex_*/mem_* inputs SHALL be ignored.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state IDLE;
- dm_req_o=0;
- all registered outputs to 0;
- the wait counter to 0.
REQ-031 Reset during ACCESS SHALL abandon the access with no fault reported; a dm_ack_i arriving after reset is released SHALL be ignored.

Verification
REQ-032 Non-memory op ex_wd=5, wreg=1, wdata=0x1234, stall=0 -> mem_wd_o=5, mem_wreg_o=1, mem_wdata_o=0x1234 one edge later, stallreq_o=0 throughout.
REQ-033 Byte load, addr=0x003, sel=000, ack after 2 wait cycles, rdata=0x80FF_FF00 -> dm_be_o=1000, stallreq_o high for 4 cycles, result 0xFFFF_FF80, wreg=1.
REQ-034 Half store, addr=0x00A, data=0x0000_BEEF -> dm_we_o=1, dm_addr_o=0x008, dm_be_o=1100, dm_wdata_o=0xBEEF_BEEF; on completion wreg=0.
REQ-035 Word load at addr=0x006 -> no dm_req_o, fault_o pulses once, fault_code_o=01, fault_addr_o=0x006, mem_wreg_o=0.
REQ-036 Load with no ack for 16 cycles -> abort, fault_code_o=10, state IDLE.
REQ-037 Separately, rst asserted mid-access -> dm_req_o=0 at once, no fault_o.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage: forwards EX results to write-back, or runs a single
// aligned load/store on the data-memory port, with misalignment and timeout faults.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd_i,
    input  logic        ex_wreg_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [1:0]  mem_rw_i,
    input  logic [11:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [5:0]  stall,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [11:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic [4:0]  mem_wd_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_wdata_o,
    output logic        stallreq_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o,
    output logic [11:0] fault_addr_o
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [1:0] FAULT_ALIGN   = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    state_t      state_reg, state_next;
    logic [4:0]  wd_reg, wd_next;
    logic        store_reg, store_next;
    logic [11:0] addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    logic [1:0]  size_reg, size_next;
    logic        uns_reg, uns_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [4:0]  out_wd_reg, out_wd_next;
    logic        out_wreg_reg, out_wreg_next;
    logic [31:0] out_wdata_reg, out_wdata_next;
    logic        fault_reg, fault_next;
    logic [1:0]  fault_code_reg, fault_code_next;
    logic [11:0] fault_addr_reg, fault_addr_next;

    logic        is_mem_op;
    logic        misaligned;
    logic        aligned_op;
    logic        misaligned_op;
    logic [7:0]  rd_byte [4];
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_result;
    logic        unused_inputs;

    assign unused_inputs = ^{stall[3:0], mem_sel_i[3]};

    // Request decode; size 11 is treated as a word, so any set bit 1 means word alignment.
    assign is_mem_op     = (mem_rw_i == 2'b01) || (mem_rw_i == 2'b10);
    assign misaligned    = ((mem_sel_i[1:0] == 2'b01) && mem_addr_i[0]) ||
                           (mem_sel_i[1] && (mem_addr_i[1:0] != 2'b00));
    assign aligned_op    = is_mem_op && !misaligned;
    assign misaligned_op = is_mem_op && misaligned;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_byte[gi] = dm_rdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        load_byte = rd_byte[addr_reg[1:0]];
        load_half = addr_reg[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
        case (size_reg)
            2'b00:   load_result = uns_reg ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_result = uns_reg ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_result = dm_rdata_i;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        wd_next         = wd_reg;
        store_next      = store_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        size_next       = size_reg;
        uns_next        = uns_reg;
        cnt_next        = cnt_reg;
        out_wd_next     = out_wd_reg;
        out_wreg_next   = out_wreg_reg;
        out_wdata_next  = out_wdata_reg;
        fault_next      = 1'b0;
        fault_code_next = fault_code_reg;
        fault_addr_next = fault_addr_reg;

        case (state_reg)
            IDLE: begin
                if (!stall[5]) begin
                    if (aligned_op) begin
                        state_next     = ACCESS;
                        wd_next        = ex_wd_i;
                        store_next     = (mem_rw_i == 2'b10);
                        addr_next      = mem_addr_i;
                        data_next      = mem_data_i;
                        size_next      = mem_sel_i[1:0];
                        uns_next       = mem_sel_i[2];
                        cnt_next       = 4'd0;
                        out_wd_next    = 5'd0;
                        out_wreg_next  = 1'b0;
                        out_wdata_next = 32'd0;
                    end else if (misaligned_op || stall[4]) begin
                        out_wd_next    = 5'd0;
                        out_wreg_next  = 1'b0;
                        out_wdata_next = 32'd0;
                        if (misaligned_op) begin
                            fault_next      = 1'b1;
                            fault_code_next = FAULT_ALIGN;
                            fault_addr_next = mem_addr_i;
                        end
                    end else begin
                        out_wd_next    = ex_wd_i;
                        out_wreg_next  = ex_wreg_i;
                        out_wdata_next = ex_wdata_i;
                    end
                end
            end
            ACCESS: begin
                if (dm_ack_i) begin
                    state_next     = IDLE;
                    out_wd_next    = store_reg ? 5'd0 : wd_reg;
                    out_wreg_next  = !store_reg;
                    out_wdata_next = store_reg ? 32'd0 : load_result;
                end else if (cnt_reg == 4'd15) begin
                    state_next      = IDLE;
                    out_wd_next     = 5'd0;
                    out_wreg_next   = 1'b0;
                    out_wdata_next  = 32'd0;
                    fault_next      = 1'b1;
                    fault_code_next = FAULT_TIMEOUT;
                    fault_addr_next = addr_reg;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            wd_reg         <= 5'd0;
            store_reg      <= 1'b0;
            addr_reg       <= 12'd0;
            data_reg       <= 32'd0;
            size_reg       <= 2'b00;
            uns_reg        <= 1'b0;
            cnt_reg        <= 4'd0;
            out_wd_reg     <= 5'd0;
            out_wreg_reg   <= 1'b0;
            out_wdata_reg  <= 32'd0;
            fault_reg      <= 1'b0;
            fault_code_reg <= 2'b00;
            fault_addr_reg <= 12'd0;
        end else begin
            state_reg      <= state_next;
            wd_reg         <= wd_next;
            store_reg      <= store_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            size_reg       <= size_next;
            uns_reg        <= uns_next;
            cnt_reg        <= cnt_next;
            out_wd_reg     <= out_wd_next;
            out_wreg_reg   <= out_wreg_next;
            out_wdata_reg  <= out_wdata_next;
            fault_reg      <= fault_next;
            fault_code_reg <= fault_code_next;
            fault_addr_reg <= fault_addr_next;
        end
    end

    // Memory port is a pure function of the latched op, so reset drops it immediately.
    always_comb begin
        dm_req_o   = (state_reg == ACCESS);
        dm_we_o    = 1'b0;
        dm_addr_o  = 12'd0;
        dm_be_o    = 4'b0000;
        dm_wdata_o = 32'd0;
        if (state_reg == ACCESS) begin
            dm_we_o   = store_reg;
            dm_addr_o = {addr_reg[11:2], 2'b00};
            case (size_reg)
                2'b00: begin
                    dm_be_o    = 4'b0001 << addr_reg[1:0];
                    dm_wdata_o = {4{data_reg[7:0]}};
                end
                2'b01: begin
                    dm_be_o    = 4'b0011 << addr_reg[1:0];
                    dm_wdata_o = {2{data_reg[15:0]}};
                end
                default: begin
                    dm_be_o    = 4'b1111;
                    dm_wdata_o = data_reg;
                end
            endcase
        end
    end

    assign stallreq_o   = (state_reg == ACCESS) || aligned_op;
    assign mem_wd_o     = out_wd_reg;
    assign mem_wreg_o   = out_wreg_reg;
    assign mem_wdata_o  = out_wdata_reg;
    assign fault_o      = fault_reg;
    assign fault_code_o = fault_code_reg;
    assign fault_addr_o = fault_addr_reg;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stimulus pushes expected bus/write-back/fault records,
// a negedge monitor pops and compares them as the DUT presents each event.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i;
    logic [1:0]  mem_rw_i;
    logic [11:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [3:0]  mem_sel_i;
    logic [5:0]  stall;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [11:0] dm_addr_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
    logic [4:0]  mem_wd_o;
    logic        mem_wreg_o;
    logic [31:0] mem_wdata_o;
    logic        stallreq_o;
    logic        fault_o;
    logic [1:0]  fault_code_o;
    logic [11:0] fault_addr_o;

    mem_access dut (
        .clk(clk), .rst(rst),
        .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
        .mem_rw_i(mem_rw_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_sel_i(mem_sel_i), .stall(stall),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
        .dm_be_o(dm_be_o), .dm_wdata_o(dm_wdata_o),
        .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i),
        .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
        .stallreq_o(stallreq_o), .fault_o(fault_o),
        .fault_code_o(fault_code_o), .fault_addr_o(fault_addr_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fault_seen = 0;

    logic [48:0] bus_q[$];    // {we, addr, be, wdata}
    logic [37:0] wb_q[$];     // {wd, wreg, wdata}
    logic [13:0] fault_q[$];  // {code, addr}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_wd_i    = 5'd0;
        ex_wreg_i  = 1'b0;
        ex_wdata_i = 32'd0;
        mem_rw_i   = 2'b00;
        mem_addr_i = 12'd0;
        mem_data_i = 32'd0;
        mem_sel_i  = 4'd0;
        stall      = 6'd0;
    endtask

    // ex_wreg/ex_wdata are non-zero so a bubble is distinguishable from pass-through.
    task automatic issue(input logic [1:0] rw, input logic [11:0] addr,
                         input logic [31:0] data, input logic [3:0] sel, input logic [4:0] wd);
        ex_wd_i    = wd;
        ex_wreg_i  = 1'b1;
        ex_wdata_i = 32'h0000_0055;
        mem_rw_i   = rw;
        mem_addr_i = addr;
        mem_data_i = data;
        mem_sel_i  = sel;
        stall      = 6'd0;
    endtask

    task automatic do_access(input string name, input logic [1:0] rw, input logic [11:0] addr,
                             input logic [31:0] data, input logic [3:0] sel, input logic [4:0] wd,
                             input logic [31:0] rdata, input int waits,
                             input logic [48:0] exp_bus, input logic [37:0] exp_wb,
                             output int sreq_cycles);
        sreq_cycles = 0;
        issue(rw, addr, data, sel, wd);
        #1;
        sreq_cycles += int'(stallreq_o);
        bus_q.push_back(exp_bus);
        wb_q.push_back(exp_wb);
        step();
        idle_inputs();
        for (int i = 0; i < waits; i++) begin
            sreq_cycles += int'(stallreq_o);
            step();
        end
        sreq_cycles += int'(stallreq_o);
        dm_ack_i   = 1'b1;
        dm_rdata_i = rdata;
        step();
        dm_ack_i   = 1'b0;
        dm_rdata_i = 32'd0;
        $display("txn %s addr=%h waits=%0d stallreq_cycles=%0d", name, addr, waits, sreq_cycles);
    endtask

    // Monitor: request rise -> bus record, request fall -> write-back record, fault pulse -> fault record.
    initial begin
        logic prev_req;
        logic [48:0] eb;
        logic [37:0] ew;
        logic [13:0] ef;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (dm_req_o && !prev_req) begin
                    if (bus_q.size() == 0) chk("unexpected_access", 1, 0);
                    else begin
                        eb = bus_q.pop_front();
                        chk("bus_we", dm_we_o, eb[48]);
                        chk("bus_addr", dm_addr_o, eb[47:36]);
                        chk("bus_be", dm_be_o, eb[35:32]);
                        chk("bus_wdata", dm_wdata_o, eb[31:0]);
                    end
                end
                if (!dm_req_o && prev_req) begin
                    if (wb_q.size() == 0) chk("unexpected_completion", 1, 0);
                    else begin
                        ew = wb_q.pop_front();
                        chk("wb_wd", mem_wd_o, ew[37:33]);
                        chk("wb_wreg", mem_wreg_o, ew[32]);
                        chk("wb_wdata", mem_wdata_o, ew[31:0]);
                    end
                end
                if (fault_o) begin
                    fault_seen++;
                    if (fault_q.size() == 0) chk("unexpected_fault", 1, 0);
                    else begin
                        ef = fault_q.pop_front();
                        chk("fault_code", fault_code_o, ef[13:12]);
                        chk("fault_addr", fault_addr_o, ef[11:0]);
                    end
                end
                prev_req = dm_req_o;
            end
        end
    end

    initial begin
        int n;
        rst        = 1'b1;
        dm_ack_i   = 1'b0;
        dm_rdata_i = 32'd0;
        idle_inputs();
        step();
        step();
        chk("rst_dm_req", dm_req_o, 0);
        chk("rst_wreg", mem_wreg_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_stallreq", stallreq_o, 0);
        rst = 1'b0;
        step();

        // Pass-through, hold under stall[5], bubble under stall[4]
        ex_wd_i = 5'd5; ex_wreg_i = 1'b1; ex_wdata_i = 32'h0000_1234;
        #1 chk("pass_stallreq", stallreq_o, 0);
        step();
        chk("pass_wd", mem_wd_o, 5);
        chk("pass_wreg", mem_wreg_o, 1);
        chk("pass_wdata", mem_wdata_o, 32'h1234);
        chk("pass_stallreq_after", stallreq_o, 0);
        $display("txn pass wd=%0d wdata=%h", mem_wd_o, mem_wdata_o);
        ex_wd_i = 5'd7; ex_wdata_i = 32'h0000_9999; stall = 6'b100000;
        step();
        chk("hold_wd", mem_wd_o, 5);
        chk("hold_wdata", mem_wdata_o, 32'h1234);
        $display("txn stall5 hold");
        stall = 6'b010000;
        step();
        chk("bubble_wreg", mem_wreg_o, 0);
        chk("bubble_wdata", mem_wdata_o, 0);
        $display("txn stall4 bubble");
        idle_inputs();
        step();

        // Signed byte load, two wait cycles
        do_access("ld_byte", 2'b01, 12'h003, 32'd0, 4'b0000, 5'd9, 32'h80FF_FF00, 2,
                  {1'b0, 12'h000, 4'b1000, 32'h0}, {5'd9, 1'b1, 32'hFFFF_FF80}, n);
        chk("ld_byte_stallreq_cycles", n, 4);
        chk("ld_byte_stallreq_after", stallreq_o, 0);
        // Half store
        do_access("st_half", 2'b10, 12'h00A, 32'h0000_BEEF, 4'b0001, 5'd3, 32'd0, 0,
                  {1'b1, 12'h008, 4'b1100, 32'hBEEF_BEEF}, {5'd0, 1'b0, 32'h0}, n);
        // Byte store
        do_access("st_byte", 2'b10, 12'h001, 32'h1234_56A5, 4'b0000, 5'd2, 32'd0, 1,
                  {1'b1, 12'h000, 4'b0010, 32'hA5A5_A5A5}, {5'd0, 1'b0, 32'h0}, n);
        // Unsigned upper-half load
        do_access("ld_half_u", 2'b01, 12'h006, 32'd0, 4'b0101, 5'd11, 32'h8001_1234, 1,
                  {1'b0, 12'h004, 4'b1100, 32'h0}, {5'd11, 1'b1, 32'h0000_8001}, n);
        // Signed lower-half load
        do_access("ld_half_s", 2'b01, 12'h000, 32'd0, 4'b0001, 5'd13, 32'h1234_F00D, 0,
                  {1'b0, 12'h000, 4'b0011, 32'h0}, {5'd13, 1'b1, 32'hFFFF_F00D}, n);
        // Word load
        do_access("ld_word", 2'b01, 12'h010, 32'd0, 4'b0010, 5'd12, 32'hDEAD_BEEF, 3,
                  {1'b0, 12'h010, 4'b1111, 32'h0}, {5'd12, 1'b1, 32'hDEAD_BEEF}, n);

        // Misaligned word load
        issue(2'b01, 12'h006, 32'd0, 4'b0010, 5'd4);
        #1 chk("misalign_stallreq", stallreq_o, 0);
        fault_q.push_back({2'b01, 12'h006});
        step();
        chk("misalign_dm_req", dm_req_o, 0);
        chk("misalign_wreg", mem_wreg_o, 0);
        idle_inputs();
        step();
        chk("misalign_fault_one_cycle", fault_o, 0);
        chk("misalign_code_hold", fault_code_o, 2'b01);
        chk("misalign_addr_hold", fault_addr_o, 12'h006);
        $display("txn misaligned addr=006");

        // Timeout: 16 access cycles without ack
        issue(2'b01, 12'h004, 32'd0, 4'b0000, 5'd6);
        bus_q.push_back({1'b0, 12'h004, 4'b0001, 32'h0});
        wb_q.push_back({5'd0, 1'b0, 32'h0});
        fault_q.push_back({2'b10, 12'h004});
        step();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("timeout_req_at_15", dm_req_o, 1);
            step();
        end
        chk("timeout_dm_req", dm_req_o, 0);
        chk("timeout_stallreq", stallreq_o, 0);
        chk("timeout_code", fault_code_o, 2'b10);
        $display("txn timeout addr=004");
        step();

        // Ack coinciding with count 15 completes normally
        do_access("ld_ack15", 2'b01, 12'h020, 32'd0, 4'b0010, 5'd17, 32'h0BAD_F00D, 15,
                  {1'b0, 12'h020, 4'b1111, 32'h0}, {5'd17, 1'b1, 32'h0BAD_F00D}, n);
        chk("ack15_stallreq_cycles", n, 17);
        step();

        // Reset mid-access
        issue(2'b01, 12'h040, 32'd0, 4'b0010, 5'd8);
        bus_q.push_back({1'b0, 12'h040, 4'b1111, 32'h0});
        step();
        idle_inputs();
        step();
        #1 rst = 1'b1;
        #1;
        chk("rstmid_dm_req", dm_req_o, 0);
        chk("rstmid_stallreq", stallreq_o, 0);
        chk("rstmid_wreg", mem_wreg_o, 0);
        step();
        rst      = 1'b0;
        dm_ack_i = 1'b1;
        step();
        step();
        chk("rstmid_late_ack_req", dm_req_o, 0);
        chk("rstmid_no_fault", fault_o, 0);
        dm_ack_i = 1'b0;
        $display("txn reset mid-access");
        step();

        chk("fault_pulse_count", fault_seen, 2);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        chk("fault_q_drained", fault_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
